// File: rtl/int_ctrl_pkg.sv
// Shared constants for the memory-mapped peripherals around the CPU: timer and
// bridge address map, interrupt controller register offsets, FSM encoding and
// the priority-encoder result type.
package int_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ID_W   = 3;

  // Bridge address map (16-byte windows).
  localparam logic [ADDR_W-1:0] TC1_BASE       = 32'h0000_7F00;
  localparam logic [ADDR_W-1:0] TC2_BASE       = 32'h0000_7F10;
  localparam logic [ADDR_W-1:0] INT_CTRL_BASE  = 32'h0000_7F30;
  localparam int unsigned       BRIDGE_WIN_B   = 16;

  // Interrupt controller register offsets inside its window.
  localparam logic [3:0] OFS_MASK = 4'h0;
  localparam logic [3:0] OFS_PEND = 4'h4;
  localparam logic [3:0] OFS_MODE = 4'h8;
  localparam logic [3:0] OFS_CUR  = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_e;

  // Fixed-priority encoder result.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } prio_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest-index set request wins.
// Ports:
//   req_i    - request vector
//   res_c_o  - combinational {valid, id} of the winning request
module prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 6
) (
  input  logic [N_SRC-1:0] req_i,
  output prio_t            res_c_o
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    res_c_o = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        res_c_o.valid = 1'b1;
        res_c_o.id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches edge/level sources into PEND, masks them,
// picks the lowest-index eligible source and runs an IDLE/REQ/SERV handshake
// with the CPU (ack on exception entry, EOI via a write to CUR).
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   src        - raw interrupt sources (bit 0 = TC1, 1 = TC2, 2 = external)
//   addr, we, wdata, rdata - bus register window (rdata combinational)
//   ack        - CPU exception-taken pulse
//   irq, vec   - registered request and source ID to the CPU
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int unsigned       N_SRC = 6,
  parameter logic [ADDR_W-1:0] BASE  = INT_CTRL_BASE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  src,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              ack,
  output logic              irq,
  output logic [ID_W-1:0]   vec
);

  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] src_q;
  state_e           state_q, state_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  vec_q, vec_d;

  logic             hit;
  logic [3:0]       ofs;
  logic             wr_mask, wr_pend, wr_mode, wr_cur;
  logic             eoi;
  logic             take;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] eligible;
  prio_t            win;

  logic unused_bits;
  assign unused_bits = ^{wdata[DATA_W-1:N_SRC], addr[1:0]};

  // Register window decode (word granularity).
  assign hit     = (addr[ADDR_W-1:4] == BASE[ADDR_W-1:4]);
  assign ofs     = {addr[3:2], 2'b00};
  assign wr_mask = we && hit && (ofs == OFS_MASK);
  assign wr_pend = we && hit && (ofs == OFS_PEND);
  assign wr_mode = we && hit && (ofs == OFS_MODE);
  assign wr_cur  = we && hit && (ofs == OFS_CUR);
  assign eoi     = wr_cur && (state_q == ST_SERV);

  assign eligible = pend_q & mask_q;

  prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .req_i   (eligible),
    .res_c_o (win)
  );

  // Ack in REQ hands the current winner to the CPU.
  assign take = ack && (state_q == ST_REQ) && win.valid;

  // Pending update: edge bits set on rise (set beats W1C/ack clear), level bits follow src.
  always_comb begin
    rise    = src & ~src_q;
    w1c     = wr_pend ? wdata[N_SRC-1:0] : '0;
    ack_clr = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      ack_clr[i] = take && (win.id == ID_W'(i));
    end
    mask_d = wr_mask ? wdata[N_SRC-1:0] : mask_q;
    mode_d = wr_mode ? wdata[N_SRC-1:0] : mode_q;
    pend_d = (mode_q & ((pend_q & ~w1c & ~ack_clr) | rise)) | (~mode_q & src);
  end

  // Request/service FSM next state and registered outputs.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    vec_d   = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        irq_d = 1'b0;
        if (win.valid) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          vec_d   = win.id;
        end
      end
      ST_REQ: begin
        if (!win.valid) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end else if (ack) begin
          state_d = ST_SERV;
          irq_d   = 1'b0;
          vec_d   = win.id;
        end else begin
          irq_d   = 1'b1;
          vec_d   = win.id;
        end
      end
      ST_SERV: begin
        irq_d = 1'b0;
        if (eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q  <= '0;
      pend_q  <= '0;
      mode_q  <= '0;
      src_q   <= '0;
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      src_q   <= src;
      state_q <= state_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
    end
  end

  // Combinational read-back; zero outside the window.
  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (ofs)
        OFS_MASK: rdata = DATA_W'(mask_q);
        OFS_PEND: rdata = DATA_W'(pend_q);
        OFS_MODE: rdata = DATA_W'(mode_q);
        OFS_CUR:  rdata = {(state_q == ST_SERV), 28'b0, vec_q};
        default:  rdata = '0;
      endcase
    end
  end

  assign irq = irq_q;
  assign vec = vec_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus queues expected register/pin values
// and expected IDs for each irq raise; a negedge monitor pops and compares.
module tb_int_ctrl;

  localparam logic [31:0] A_MASK = 32'h0000_7F30;
  localparam logic [31:0] A_PEND = 32'h0000_7F34;
  localparam logic [31:0] A_MODE = 32'h0000_7F38;
  localparam logic [31:0] A_CUR  = 32'h0000_7F3C;

  localparam int K_RD  = 0;
  localparam int K_IRQ = 1;
  localparam int K_VEC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src = '0;
  logic [31:0] stim_addr = '0;
  logic [31:0] mon_addr = '0;
  logic        mon_rd = 1'b0;
  logic [31:0] addr;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack = 1'b0;
  logic        irq;
  logic [2:0]  vec;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t      chk_q[$];
  logic [2:0] raise_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign addr = mon_rd ? mon_addr : stim_addr;

  always #10 clk = ~clk;

  int_ctrl #(.N_SRC(6), .BASE(32'h0000_7F30)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .irq   (irq),
    .vec   (vec)
  );

  task automatic push(input int k, input logic [31:0] a, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = k;
    it.a    = a;
    it.exp  = e;
    it.name = nm;
    chk_q.push_back(it);
  endtask

  task automatic exp_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    push(K_RD, a, e, nm);
  endtask

  task automatic exp_irq(input logic e, input string nm);
    push(K_IRQ, '0, 32'(e), nm);
  endtask

  task automatic exp_vec(input logic [2:0] e, input string nm);
    push(K_VEC, '0, 32'(e), nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    stim_addr = a;
    wdata     = d;
    we        = 1'b1;
    step();
    we        = 1'b0;
    stim_addr = '0;
  endtask

  // Monitor: irq raises are checked against queued IDs, then queued checks are drained.
  initial begin
    logic        irq_prev;
    logic [31:0] act;
    logic [2:0]  ev;
    item_t       it;
    irq_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (irq === 1'b1 && irq_prev !== 1'b1) begin
        n_cmp++;
        if (raise_q.size() == 0) begin
          n_bad++;
          $display("FAIL irq_raise: got raise with vec=%0d, required no raise", vec);
        end else begin
          ev = raise_q.pop_front();
          if (vec !== ev) begin
            n_bad++;
            $display("FAIL irq_raise_vec: got %0d, required %0d", vec, ev);
          end
        end
      end
      irq_prev = irq;
      while (chk_q.size() > 0) begin
        it = chk_q.pop_front();
        if (it.kind == K_RD) begin
          mon_addr = it.a;
          mon_rd   = 1'b1;
          #1;
          act      = rdata;
          mon_rd   = 1'b0;
        end else if (it.kind == K_IRQ) begin
          act = 32'(irq);
        end else begin
          act = 32'(vec);
        end
        n_cmp++;
        if (act !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    exp_rd(A_MASK, 32'h0, "rst_mask");
    exp_rd(A_PEND, 32'h0, "rst_pend");
    exp_rd(A_MODE, 32'h0, "rst_mode");
    exp_rd(A_CUR,  32'h0, "rst_cur");
    exp_irq(1'b0, "rst_irq");
    exp_vec(3'd0, "rst_vec");
    step();
    step();
    reset = 1'b1;
    step();

    // Scenario 1: edge source 0, latency and ack
    wr(A_MASK, 32'h3F);
    wr(A_MODE, 32'h01);
    src = 6'h01;
    step();
    src = 6'h00;
    exp_rd(A_PEND, 32'h01, "s1_pend_set");
    exp_irq(1'b0, "s1_irq_not_yet");
    raise_q.push_back(3'd0);
    step();
    exp_irq(1'b1, "s1_irq");
    exp_vec(3'd0, "s1_vec");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_irq(1'b0, "s1_irq_after_ack");
    exp_rd(A_PEND, 32'h00, "s1_pend_cleared");
    exp_rd(A_CUR, 32'h8000_0000, "s1_cur_serv");
    wr(A_CUR, 32'h0);
    exp_rd(A_CUR, 32'h0, "s1_cur_idle");

    // Scenario 2: simultaneous sources 1 and 2
    wr(A_MODE, 32'h07);
    src = 6'h06;
    step();
    src = 6'h00;
    raise_q.push_back(3'd1);
    step();
    exp_irq(1'b1, "s2_irq");
    exp_vec(3'd1, "s2_vec1");
    exp_rd(A_PEND, 32'h06, "s2_pend");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_rd(A_CUR, 32'h8000_0001, "s2_cur_serv");
    exp_rd(A_PEND, 32'h04, "s2_pend_after_ack");
    exp_irq(1'b0, "s2_irq_serv");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_rd(A_CUR, 32'h8000_0001, "s2_ack_in_serv_ignored");
    exp_rd(A_PEND, 32'h04, "s2_pend_kept_in_serv");
    raise_q.push_back(3'd2);
    wr(A_CUR, 32'h0);
    exp_irq(1'b0, "s2_irq_after_eoi");
    exp_rd(A_CUR, 32'h1, "s2_cur_idle");
    step();
    exp_irq(1'b1, "s2_irq_rereq");
    exp_vec(3'd2, "s2_vec2");
    exp_rd(A_CUR, 32'h2, "s2_cur_req");

    // Scenario 3: preemption by source 0 while requesting 2
    src = 6'h01;
    step();
    src = 6'h00;
    exp_vec(3'd2, "s3_vec_before");
    exp_irq(1'b1, "s3_irq_held");
    step();
    exp_vec(3'd0, "s3_vec_preempt");
    exp_irq(1'b1, "s3_irq_still");
    exp_rd(A_PEND, 32'h05, "s3_pend");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_rd(A_CUR, 32'h8000_0000, "s3_cur_serv0");
    exp_rd(A_PEND, 32'h04, "s3_pend_after_ack");
    exp_irq(1'b0, "s3_irq_serv");
    raise_q.push_back(3'd2);
    wr(A_CUR, 32'h0);
    step();
    exp_irq(1'b1, "s3_irq_rereq");
    exp_vec(3'd2, "s3_vec2");

    // Scenario 4: masking withdraws the request, unmasking re-raises it
    wr(A_MASK, 32'h0);
    exp_irq(1'b1, "s4_irq_write_edge");
    step();
    exp_irq(1'b0, "s4_irq_masked");
    exp_rd(A_PEND, 32'h04, "s4_pend_kept");
    exp_rd(A_CUR, 32'h2, "s4_cur_idle");
    raise_q.push_back(3'd2);
    wr(A_MASK, 32'h3F);
    exp_irq(1'b0, "s4_irq_unmask_edge");
    step();
    exp_irq(1'b1, "s4_irq_reraised");
    exp_vec(3'd2, "s4_vec");
    ack = 1'b1;
    step();
    ack = 1'b0;
    wr(A_CUR, 32'h0);
    exp_irq(1'b0, "s4_irq_done");
    exp_rd(A_PEND, 32'h0, "s4_pend_empty");
    exp_rd(A_CUR, 32'h2, "s4_cur_idle2");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_irq(1'b0, "s4_ack_in_idle_ignored");
    exp_rd(A_CUR, 32'h2, "s4_cur_after_idle_ack");

    // Scenario 5: level source vs W1C, and set-wins on an edge bit
    wr(A_MODE, 32'h03);
    wr(A_MASK, 32'h0);
    src = 6'h04;
    step();
    exp_rd(A_PEND, 32'h04, "s5_level_set");
    wr(A_PEND, 32'h04);
    exp_rd(A_PEND, 32'h04, "s5_level_w1c_no_effect");
    src = 6'h05;
    wr(A_PEND, 32'h01);
    exp_rd(A_PEND, 32'h05, "s5_set_beats_w1c");
    wr(A_PEND, 32'h01);
    exp_rd(A_PEND, 32'h04, "s5_w1c_edge_bit");
    src = 6'h00;
    step();
    exp_rd(A_PEND, 32'h00, "s5_level_follows");
    exp_irq(1'b0, "s5_irq_masked");

    // Scenario 6: asynchronous reset while in service
    wr(A_MODE, 32'h01);
    wr(A_MASK, 32'h3F);
    src = 6'h01;
    step();
    src = 6'h00;
    raise_q.push_back(3'd0);
    step();
    exp_irq(1'b1, "s6_irq");
    ack = 1'b1;
    step();
    ack = 1'b0;
    exp_rd(A_CUR, 32'h8000_0000, "s6_cur_serv");
    step();
    #2;
    reset = 1'b0;
    exp_irq(1'b0, "s6_rst_irq");
    exp_vec(3'd0, "s6_rst_vec");
    exp_rd(A_CUR,  32'h0, "s6_rst_cur");
    exp_rd(A_MASK, 32'h0, "s6_rst_mask");
    exp_rd(A_PEND, 32'h0, "s6_rst_pend");
    exp_rd(A_MODE, 32'h0, "s6_rst_mode");
    step();
    reset = 1'b1;
    wr(A_MASK, 32'h3F);
    wr(A_MODE, 32'h01);
    step();
    step();
    exp_irq(1'b0, "s6_no_irq_after_release");
    exp_rd(A_PEND, 32'h0, "s6_pend_after_release");
    step();
    src = 6'h01;
    step();
    src = 6'h00;
    raise_q.push_back(3'd0);
    step();
    exp_irq(1'b1, "s6_irq_new_edge");
    exp_vec(3'd0, "s6_vec_new_edge");
    step();
    step();

    n_cmp++;
    if (raise_q.size() != 0) begin
      n_bad++;
      $display("FAIL irq_raise_missing: got %0d unserved expected raises, required 0", raise_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter N_SRC, default 6: number of interrupt sources; bit order matches HWInt, so bit 0 is TC1, bit 1 is TC2, bit 2 is the external interrupt.
REQ-002 Parameter BASE, default 32'h0000_7F30: word-aligned base address of the 16-byte register window.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-low: reset=0 clears all state immediately.
REQ-005 src  input  N_SRC  raw interrupt sources, synchronous to clk.
REQ-006 addr  input  32  bus byte address from the bridge.
REQ-007 we  input  1  bus write strobe; takes effect only when addr falls inside the window.
REQ-008 wdata  input  32  bus write data.
REQ-009 rdata  output  32  combinational read data for addr; 0 outside the window.
REQ-010 ack  input  1  one-cycle pulse from the CPU when it takes the interrupt exception.
REQ-011 irq  output  1  registered interrupt request to the CPU.
REQ-012 vec  output  3  registered ID of the source being requested or serviced.

Function
REQ-013 Registers: MASK at +0x0 (RW, bits[N_SRC-1:0]), PEND at +0x4 (read; writing 1 clears that bit), MODE at +0x8 (RW; 1 = edge, 0 = level), CUR at +0xC (read {active, 28'b0, vec}; any write = end-of-interrupt, EOI).
REQ-014 Edge-mode source, rising edge detected (src=1 now, src_q=0 previous cycle): PEND bit set at the next clock edge.
REQ-015 Level-mode source: PEND bit tracks src each cycle; writing 1 to clear it has no lasting effect while src=1.
REQ-016 Edge set and write-1-clear of the same bit in the same cycle: set wins.
REQ-017 eligible = PEND & MASK; winner = lowest-index set bit of eligible.
REQ-018 FSM states: IDLE, REQ, SERV.
REQ-019 IDLE -> REQ when eligible != 0; on entry, irq=1 and vec=winner.
REQ-020 In REQ, while ack=0, vec is re-evaluated every cycle so a higher-priority arrival preempts the pending request.
REQ-021 REQ -> IDLE, irq=0 on the next edge, if eligible becomes 0 before ack (for example, the source is masked).
REQ-022 REQ -> SERV on ack=1; irq=0 and vec frozen on the same edge; an edge-mode PEND[vec] is cleared on that edge.
REQ-023 SERV: irq stays 0; new pending bits accumulate but are not requested; CUR.active=1.
REQ-024 SERV -> IDLE on EOI; if eligible != 0, the controller enters REQ one cycle later.
REQ-025 ack received in IDLE or SERV is ignored; EOI received outside SERV is ignored.
REQ-026 Latency: a rising edge on an unmasked edge-mode src before clock edge k gives PEND set after edge k and irq=1 after edge k+1.

Reset
REQ-027 reset=0 forces: MASK=0, PEND=0, MODE=0, src_q=0, FSM=IDLE, irq=0, vec=0.
REQ-028 Reset asserted mid-REQ or mid-SERV drops irq to 0 immediately, without waiting for a clock edge.
REQ-029 rdata is combinational; under reset it reads the reset register values.

Structure
REQ-030 The register offsets, FSM state encodings and the BASE default shall live in the shared constants package alongside the timer and bridge address constants.
REQ-031 The fixed-priority encoder shall be one sub-module, prio_enc, parameterised on N_SRC, returning {valid, id}.
REQ-032 The module shall be instantiated next to the timers, with src = HWInt and irq/vec feeding the CPU exception logic.

Verification
REQ-033 Scenario 1: MASK=6'h3F, MODE=6'h01, pulse src[0] for 1 cycle -> PEND=0x01 after 1 edge, irq=1 and vec=0 after 2 edges; ack -> irq=0 and PEND=0.
REQ-034 Scenario 2: src[1] and src[2] rise in the same cycle, both unmasked -> vec=1; after ack and EOI -> REQ again with vec=2.
REQ-035 Scenario 3: in REQ with vec=2, src[0] rises -> vec=0 before ack; ack latches vec=0.
REQ-036 Scenario 4: in REQ, write MASK=0 -> irq=0 next edge and FSM=IDLE; PEND is kept, so restoring MASK re-raises irq.
REQ-037 Scenario 5: level source src[2]=1 held, write 0x4 to PEND -> PEND[2] still reads 1; the same cycle as an edge set on bit 0 with W1C of bit 0 -> bit 0 stays 1.
REQ-038 Scenario 6: reset=0 asserted in SERV mid-cycle -> irq=0, CUR=0 and all registers 0 immediately; after release, no irq until a new edge arrives.
